// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the radix-2 restoring divider.
//   - state_t   : FSM state encoding (IDLE / ITER / DONE)
//   - DIV_WIDTH : default operand/result width
//   - DIV_CNT_W : default iteration-counter width (must be able to hold WIDTH)
//   Ports: none (package).
// ----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division step.
//   The partial remainder and quotient are treated as one long register
//   {r,q} shifted left by one; the shifted remainder is WIDTH+1 bits wide so
//   the bit shifted out of r is kept for the compare. If the shifted remainder
//   is >= d it is reduced by d and a 1 enters the quotient LSB.
//   Ports:
//     r       in   WIDTH  current partial remainder (always < d between steps)
//     q       in   WIDTH  current quotient / remaining dividend bits
//     d       in   WIDTH  divisor magnitude
//     r_next  out  WIDTH  partial remainder after this step
//     q_next  out  WIDTH  quotient after this step
// ----------------------------------------------------------------------------
import div_pkg::*;

module div_step #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] r_diff;
    logic           ge;

    assign r_shift = {r, q[WIDTH-1]};
    assign r_diff  = r_shift - {1'b0, d};
    assign ge      = (r_shift >= {1'b0, d});

    // After a successful subtract the result is < d, so it always fits in
    // WIDTH bits. When d==0 the shifted-out bit is still 0 because r only
    // ever holds the dividend bits shifted in so far.
    assign r_next = ge ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
    assign q_next = {q[WIDTH-2:0], ge};

    // r_diff's top bit is only meaningful as a borrow, which ge already covers.
    logic unused_borrow;
    assign unused_borrow = r_diff[WIDTH];

endmodule

// File: rtl/radix2_divider.sv
// ----------------------------------------------------------------------------
// radix2_divider
//   Iterative radix-2 restoring divider for DIV / DIVU. Responder side of an
//   en/complete handshake: the initiator holds en high until complete pulses.
//   One quotient bit per cycle; latency from first en cycle to complete is
//   WIDTH+1 cycles. Results are registered and held until the next start.
//   Dropping en during iteration aborts the operation (results unchanged,
//   no complete).
//
//   Optional build macro RADIX2_DIV_ZERO_FAST_EN: when defined, a start with
//   divisor==0 skips iteration and completes one cycle later with
//   quotient=all-ones, remainder=raw dividend. When undefined, divide by zero
//   runs full length: quotient magnitude all-ones, remainder |dividend|, both
//   sign-corrected like any other result.
//
//   Ports:
//     clk        in   1      rising-edge clock
//     reset      in   1      synchronous, active-high
//     en         in   1      request / hold; low during iteration = abort
//     is_signed  in   1      1: two's-complement DIV, 0: DIVU
//     dividend   in   WIDTH  numerator, sampled on start only
//     divisor    in   WIDTH  denominator, sampled on start only
//     quotient   out  WIDTH  registered quotient
//     remainder  out  WIDTH  registered remainder
//     complete   out  1      one-cycle pulse: results valid this cycle
// ----------------------------------------------------------------------------
import div_pkg::*;

module radix2_divider #(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             complete
);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] rem_work_reg;   // partial remainder
    logic [WIDTH-1:0] quo_work_reg;   // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_reg;        // divisor magnitude
    logic             sign_q_reg;
    logic             sign_r_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             complete_reg;

    // ------------------------------------------------------------------
    // Start-time operand conditioning
    // ------------------------------------------------------------------
    logic             dd_neg;
    logic             dv_neg;
    logic [WIDTH-1:0] dd_abs;
    logic [WIDTH-1:0] dv_abs;
    logic             fast_zero;

    assign dd_neg = is_signed & dividend[WIDTH-1];
    assign dv_neg = is_signed & divisor[WIDTH-1];
    // The most negative value negates to itself, which is also its correct
    // unsigned magnitude, so no special case is needed.
    assign dd_abs = dd_neg ? (~dividend + 1'b1) : dividend;
    assign dv_abs = dv_neg ? (~divisor + 1'b1) : divisor;

`ifdef RADIX2_DIV_ZERO_FAST_EN
    assign fast_zero = (divisor == '0);
`else
    assign fast_zero = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Single restoring step datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (rem_work_reg),
        .q      (quo_work_reg),
        .d      (dvs_reg),
        .r_next (r_step),
        .q_next (q_step)
    );

    // Sign fix-up applied to the outputs of the final step, so the result
    // registers load in the same edge that enters DONE.
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign q_fix = sign_q_reg ? (~q_step + 1'b1) : q_step;
    assign r_fix = sign_r_reg ? (~r_step + 1'b1) : r_step;

    // ------------------------------------------------------------------
    // FSM, counter, working and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            rem_work_reg  <= '0;
            quo_work_reg  <= '0;
            dvs_reg       <= '0;
            sign_q_reg    <= 1'b0;
            sign_r_reg    <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            complete_reg  <= 1'b0;
        end else begin
            complete_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (en) begin
                        if (fast_zero) begin
                            quotient_reg  <= '1;
                            remainder_reg <= dividend;
                            complete_reg  <= 1'b1;
                            state_reg     <= ST_DONE;
                        end else begin
                            rem_work_reg <= '0;
                            quo_work_reg <= dd_abs;
                            dvs_reg      <= dv_abs;
                            sign_q_reg   <= dd_neg ^ dv_neg;
                            sign_r_reg   <= dd_neg;
                            cnt_reg      <= CNT_W'(WIDTH);
                            state_reg    <= ST_ITER;
                        end
                    end
                end

                ST_ITER: begin
                    if (!en) begin
                        // Abort: result registers keep the previous answer.
                        state_reg <= ST_IDLE;
                    end else begin
                        rem_work_reg <= r_step;
                        quo_work_reg <= q_step;
                        cnt_reg      <= cnt_reg - 1'b1;
                        if (cnt_reg == CNT_W'(1)) begin
                            quotient_reg  <= q_fix;
                            remainder_reg <= r_fix;
                            complete_reg  <= 1'b1;
                            state_reg     <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    // Always return to IDLE; a still-high en there is a new start.
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign complete  = complete_reg;

endmodule

// File: tb/tb_radix2_divider.sv
// ----------------------------------------------------------------------------
// tb_radix2_divider
//   Self-checking bench for radix2_divider (WIDTH=32). Directed cases plus
//   random operands compared against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_radix2_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        complete;

    int checks = 0;
    int errors = 0;

    radix2_divider dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .complete  (complete)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] q,
                                  output logic [31:0] r);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
`ifdef RADIX2_DIV_ZERO_FAST_EN
            q = 32'hFFFF_FFFF;
            r = a;
`else
            // magnitude all-ones, negated when the signed dividend is negative;
            // remainder is -|a| = a for negative a, a otherwise
            q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
`endif
        end else if (s) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_latency(input logic [31:0] b);
`ifdef RADIX2_DIV_ZERO_FAST_EN
        if (b == 32'd0) return 1;
`endif
        return 33;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts rising edges until complete is seen (sampled at negedge).
    // Returns -1 if the bound expires. Optionally scrambles operand inputs
    // after the start edge to show they are not re-sampled.
    task automatic wait_complete(input bit scramble, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (scramble) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
            if (complete === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
        logic [31:0] eq;
        logic [31:0] er;
        int          cyc;
        model(a, b, s, eq, er);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        en        = 1'b1;
        wait_complete(1'b1, cyc);
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_latency(b)));
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        $display("op %s a=%h b=%h s=%0d q=%h r=%h lat=%0d", tag, a, b, s, quotient, remainder, cyc);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, complete}, 32'd0);
        chk({tag, "_hold_q"}, quotient, eq);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          cyc;
        int          seen;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;

        reset     = 1'b1;
        en        = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_q", quotient, 32'd0);
        chk("reset_r", remainder, 32'd0);
        chk("reset_complete", {31'd0, complete}, 32'd0);

        // directed cases
        do_op("u100_7",    32'd100,         32'd7,           1'b0);
        do_op("s_m7_2",    -32'sd7,         32'd2,           1'b1);
        do_op("s_7_m2",    32'd7,           -32'sd2,         1'b1);
        do_op("s_m7_m2",   -32'sd7,         -32'sd2,         1'b1);
        do_op("s_ovf",     32'h8000_0000,   32'hFFFF_FFFF,   1'b1);
        do_op("u_max_1",   32'hFFFF_FFFF,   32'd1,           1'b0);
        do_op("u_5_0",     32'd5,           32'd0,           1'b0);
        do_op("u_small",   32'd3,           32'd9,           1'b0);

        // abort: en dropped at cycle 10, prior result (100/7) must survive
        do_op("pre_abort", 32'd100,         32'd7,           1'b0);
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        en        = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        en   = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (complete === 1'b1) seen++;
        end
        chk("abort_no_complete", 32'(seen), 32'd0);
        chk("abort_keep_q", quotient, 32'd14);
        chk("abort_keep_r", remainder, 32'd2);
        $display("op abort q=%h r=%h completes=%0d", quotient, remainder, seen);

        // reset in mid-iteration wins over en
        dividend = 32'd1000;
        divisor  = 32'd3;
        en       = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        chk("midreset_q", quotient, 32'd0);
        chk("midreset_r", remainder, 32'd0);
        chk("midreset_complete", {31'd0, complete}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (complete === 1'b1) seen++;
        end
        chk("midreset_idle", 32'(seen), 32'd0);
        $display("op midreset q=%h r=%h completes=%0d", quotient, remainder, seen);

        // back-to-back: 50/5 then 9/4 with en held
        is_signed = 1'b0;
        dividend  = 32'd50;
        divisor   = 32'd5;
        en        = 1'b1;
        wait_complete(1'b0, cyc);
        chk("b2b1_lat", 32'(cyc), 32'd33);
        chk("b2b1_q", quotient, 32'd10);
        chk("b2b1_r", remainder, 32'd0);
        $display("op b2b1 q=%h r=%h lat=%0d", quotient, remainder, cyc);
        dividend = 32'd9;
        divisor  = 32'd4;
        wait_complete(1'b0, cyc);
        chk("b2b2_lat", 32'(cyc + 33), 32'd67);
        chk("b2b2_q", quotient, 32'd2);
        chk("b2b2_r", remainder, 32'd1);
        $display("op b2b2 q=%h r=%h lat=%0d", quotient, remainder, cyc + 33);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // random operands against the reference model
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            b = $urandom;
            if (n % 3 == 0) b = b >> $urandom_range(31, 16);
            if (b == 32'd0) b = 32'd1;
            do_op($sformatf("rnd%0d", n), a, b, 1'(n % 2));
        end

        // one more signed divide-by-zero with a negative dividend
        a = 32'hFFFF_FFF6;
        model(a, 32'd0, 1'b1, eq, er);
        do_op("s_neg_0", a, 32'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
